// File: rtl/lsu_byte_mem.sv
// Byte-addressable load/store unit with word-organised data RAM, req/rsp handshake and wait states.
// Optional macro MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW return an error instead of aligning down.
module lsu_byte_mem #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         mem [DEPTH_WORDS];

  logic [ADDR_W-3:0]   widx;
  logic [IDX_W-1:0]    ridx;
  logic                f3_bad, oor, misalign, req_err;
  logic [1:0]          off;
  logic [31:0]         lane;
  logic [31:0]         load_data;
  logic [3:0]          be;
  logic [31:0]         wd;
  logic                ram_op, mem_we;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign widx   = addr_q[ADDR_W-1:2];
  assign ridx   = widx[IDX_W-1:0];
  assign f3_bad = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11) || (we_q && f3_q[2]);
  assign oor    = ({1'b0, widx} >= DEPTH_L);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = f3_bad || oor || misalign;
  assign ram_op  = (state_q == S_ACCESS) && (cnt_q == 8'd0);
  // Write is gated by reset so a store caught by reset at its RAM-op edge is dropped.
  assign mem_we  = ram_op && we_q && !req_err && r;

  always_comb begin
    off = 2'b00;
    be  = 4'b1111;
    wd  = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        off = addr_q[1:0];
        be  = 4'b0001 << off;
        wd  = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        off = {addr_q[1], 1'b0};
        be  = 4'b0011 << off;
        wd  = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = mem[ridx] >> {off, 3'b000};

  always_comb begin
    load_data = 32'd0;
    case (f3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      3'b010:  load_data = lane;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ACCESS;
          cnt_d   = 8'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_RESP;
          err_d   = req_err;
          rdata_d = (req_err || we_q) ? 32'd0 : load_data;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture is data only; a stale capture is harmless because IDLE never uses it.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_f3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && be[b]) mem[ridx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_lsu_byte_mem.sv
// Bench for lsu_byte_mem: directed cases plus random traffic against a byte-array reference model.
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_byte_mem;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;
  localparam int WS     = 3;

  logic              clk = 1'b0;
  logic              r = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_f3 = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [DEPTH*4];
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] saved;

  lsu_byte_mem #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .r(r), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, little-endian bytes, extension by arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata,
                       output logic [31:0] exp_rdata, output logic exp_err);
    int nb, base;
    logic illegal, oor, mis;
    logic [31:0] val;
    nb      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    oor     = (addr / 4) >= DEPTH;
`ifdef MISALIGN_TRAP_EN
    mis = (addr % nb) != 0;
`else
    mis = 1'b0;
`endif
    exp_err   = illegal || oor || mis;
    exp_rdata = 32'd0;
    base      = addr - (addr % nb);
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[base+i] = wdata[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < nb; i++) val = val | (32'(mem_m[base+i]) << (8*i));
        if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
        exp_rdata = val;
      end
    end
  endtask

  task automatic run_op(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata,
                        input string tag);
    logic tok;
    logic [31:0] er;
    logic ee;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = ADDR_W'(addr);
    req_wdata = wdata;
    tok = req_ready;
    @(posedge clk);
    for (int k = 1; k <= WS + 1; k++) begin
      @(negedge clk);
      if (!busy || rsp_valid || req_ready) tok = 1'b0;
    end
    @(negedge clk);
    if (!rsp_valid || !busy) tok = 1'b0;
    obs_rdata = rsp_rdata;
    obs_err   = rsp_err;
    req_valid = 1'b0;
    @(negedge clk);
    if (busy || rsp_valid || rsp_rdata !== obs_rdata || rsp_err !== obs_err) tok = 1'b0;
    model(we, f3, addr, wdata, er, ee);
    chk({tag, " timing"}, 32'(tok), 32'd1);
    chk({tag, " rdata"}, obs_rdata, er);
    chk({tag, " err"}, 32'(obs_err), 32'(ee));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    r = 1'b1;

    for (int w = 0; w < DEPTH; w++) run_op(1'b1, 3'b010, w * 4, $urandom, "fill");

    run_op(1'b1, 3'b010, 'h010, 32'h8000_00FF, "t1 sw");
    run_op(1'b0, 3'b000, 'h010, 32'd0, "t1 lb");
    chk("t1 lb const", obs_rdata, 32'hFFFF_FFFF);
    run_op(1'b0, 3'b100, 'h011, 32'd0, "t1 lbu");
    chk("t1 lbu const", obs_rdata, 32'h0000_0000);
    run_op(1'b0, 3'b001, 'h012, 32'd0, "t1 lh");
    chk("t1 lh const", obs_rdata, 32'hFFFF_8000);
    run_op(1'b0, 3'b101, 'h012, 32'd0, "t1 lhu");
    chk("t1 lhu const", obs_rdata, 32'h0000_8000);

    run_op(1'b1, 3'b000, 'h013, 32'h0000_00AB, "t2 sb");
    run_op(1'b1, 3'b001, 'h010, 32'h0000_1234, "t2 sh");
    run_op(1'b0, 3'b010, 'h010, 32'd0, "t2 lw");
    chk("t2 lw const", obs_rdata, 32'hAB00_1234);

    run_op(1'b0, 3'b010, 'h011, 32'd0, "t3 lw mis");
`ifdef MISALIGN_TRAP_EN
    chk("t3 mis err const", 32'(obs_err), 32'd1);
    chk("t3 mis rdata const", obs_rdata, 32'd0);
    run_op(1'b1, 3'b010, 'h012, 32'h5555_5555, "t3 sw mis");
    chk("t3 sw mis err const", 32'(obs_err), 32'd1);
`else
    chk("t3 mis err const", 32'(obs_err), 32'd0);
    chk("t3 mis rdata const", obs_rdata, 32'hAB00_1234);
`endif
    run_op(1'b0, 3'b010, 'h010, 32'd0, "t3 lw after");
    chk("t3 lw after const", obs_rdata, 32'hAB00_1234);

    run_op(1'b1, 3'b010, 'h400, 32'hDEAD_BEEF, "t4 sw oor");
    chk("t4 oor err const", 32'(obs_err), 32'd1);
    run_op(1'b0, 3'b011, 'h010, 32'd0, "t4 f3 011");
    chk("t4 f3 err const", 32'(obs_err), 32'd1);
    chk("t4 f3 rdata const", obs_rdata, 32'd0);
    run_op(1'b1, 3'b100, 'h014, 32'h1234_5678, "t4 store f3 100");
    run_op(1'b0, 3'b010, 'h000, 32'd0, "t4 lw word0");

    // Reset while a store waits in ACCESS: nothing is written and outputs clear.
    run_op(1'b0, 3'b010, 'h010, 32'd0, "t6 pre lw");
    run_op(1'b0, 3'b010, 'h020, 32'd0, "t6 old lw");
    saved = obs_rdata;
    run_op(1'b0, 3'b010, 'h010, 32'd0, "t6 nonzero lw");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_f3    = 3'b010;
    req_addr  = ADDR_W'('h020);
    req_wdata = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6 busy before reset", 32'(busy), 32'd1);
    r = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 req_ready", 32'(req_ready), 32'd1);
    chk("t6 rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6 rsp_rdata", rsp_rdata, 32'd0);
    chk("t6 rsp_err", 32'(rsp_err), 32'd0);
    repeat (4) @(negedge clk);
    r = 1'b1;
    run_op(1'b0, 3'b010, 'h020, 32'd0, "t6 lw after");
    chk("t6 contents kept", obs_rdata, saved);

    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 'h3FF));
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
